// File: rtl/shapool_job_ctrl_pkg.sv
// Shared constants, status codes and state encoding for the shapool job controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shapool_pkg;

  // Job frame: 32 B midstate, 12 B message head, 2 B difficulty mask, 1 B nonce start MSB
  localparam int             JOB_LEN  = 47;
  localparam logic [5:0]     JOB_LAST = 6'(JOB_LEN - 1);
  localparam logic [5:0]     OFS_HEAD = 6'd32;
  localparam logic [5:0]     OFS_DIFF = 6'd44;
  localparam logic [5:0]     OFS_NSM  = 6'd46;

  // Result frame: status byte followed by the 32-bit candidate nonce, MSB first
  localparam int             RES_LEN  = 5;
  localparam logic [2:0]     RES_LAST = 3'(RES_LEN - 1);

  localparam logic [7:0]     STATUS_FOUND     = 8'h01;
  localparam logic [7:0]     STATUS_EXHAUSTED = 8'h02;

  // Nonce increments between a candidate's launch and its success evaluation
  localparam int             DEFAULT_NONCE_PIPE_OFFSET = 2;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/shapool_job_ctrl_if.sv
// Host byte streams: job bytes in (rx), result bytes out (tx).
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both streams; a byte moves when valid && ready at a clock edge.
interface shapool_job_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/shapool_result_tx.sv
// Serializes a 5-byte result frame (status, then 32-bit word MSB first) onto a byte stream.
// Latency: first byte valid the edge after start; one byte per accepted handshake.
// Backpressure: tx_data/tx_valid held until tx_ready; flush drops any frame in flight.
module shapool_result_tx
  import shapool_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        flush,
  input  logic [7:0]  status,
  input  logic [31:0] word,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);

  logic [31:0] rest;
  logic [2:0]  sent;

  // Final byte of the frame is being accepted this cycle
  assign done = tx_valid && tx_ready && (sent == RES_LAST);

  // Frame load, byte advance on handshake, and flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      rest     <= 32'h0;
      sent     <= 3'd0;
    end else if (flush) begin
      tx_valid <= 1'b0;
      sent     <= 3'd0;
    end else if (start) begin
      tx_valid <= 1'b1;
      tx_data  <= status;
      rest     <= word;
      sent     <= 3'd0;
    end else if (tx_valid && tx_ready) begin
      if (done) begin
        tx_valid <= 1'b0;
        sent     <= 3'd0;
      end else begin
        tx_data <= rest[31:24];
        rest    <= {rest[23:0], 8'h00};
        sent    <= sent + 3'd1;
      end
    end
  end

endmodule

// File: rtl/shapool_job_ctrl.sv
// Job controller: loads a 47-byte job, runs the pool until success, reports a 5-byte result.
// Latency: pool released on the edge accepting byte 46; result byte 0 valid the edge after success.
// Backpressure: rx_ready only in LOAD; result bytes held until tx_ready. Optional SHAPOOL_JOB_CTRL_EXHAUST_EN adds nonce-space exhaustion.
module shapool_job_ctrl
  import shapool_pkg::*;
#(
  parameter int  POOL_SIZE_LOG2    = 0,
  parameter int  NONCE_PIPE_OFFSET = DEFAULT_NONCE_PIPE_OFFSET,
  localparam int NONCE_WIDTH       = 32 - POOL_SIZE_LOG2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  shapool_job_ctrl_if.slave      host,
  input  logic                   job_abort,
  output logic                   pool_reset_n,
  output logic [255:0]           pool_sha_state,
  output logic [95:0]            pool_message_head,
  output logic [15:0]            pool_difficulty_bm,
  output logic [7:0]             pool_nonce_start_MSB,
  input  logic                   pool_success,
  input  logic [NONCE_WIDTH-1:0] pool_nonce,
  output logic                   busy
);

  state_t                 state;
  logic [5:0]             idx;
  logic                   rx_fire;
  logic                   exhausted;
  logic                   report_start;
  logic                   tx_done;
  logic [NONCE_WIDTH-1:0] cand;
  logic [7:0]             rep_status;
  logic [31:0]            rep_word;

  assign host.rx_ready = (state == ST_LOAD);
  assign busy          = (state != ST_LOAD);
  assign rx_fire       = host.rx_valid && host.rx_ready;

`ifdef SHAPOOL_JOB_CTRL_EXHAUST_EN
  logic                   wrap_seen;
  logic [NONCE_WIDTH-1:0] nonce_start;

  // The pool starts counting from the job's MSB byte with all lower bits clear
  assign nonce_start = {pool_nonce_start_MSB, {(NONCE_WIDTH-8){1'b0}}};
  // Once the counter has wrapped, returning to the start (plus pipeline lag) means every nonce was tried
  assign exhausted   = wrap_seen &&
                       (pool_nonce == nonce_start + NONCE_WIDTH'(NONCE_PIPE_OFFSET));
  // Success on the same cycle wins over exhaustion
  assign cand        = pool_success ? (pool_nonce - NONCE_WIDTH'(NONCE_PIPE_OFFSET))
                                    : (nonce_start - NONCE_WIDTH'(1));
`else
  assign exhausted   = 1'b0;
  assign cand        = pool_nonce - NONCE_WIDTH'(NONCE_PIPE_OFFSET);
`endif

  assign report_start = (state == ST_RUN) && !job_abort && (pool_success || exhausted);
  assign rep_status   = pool_success ? STATUS_FOUND : STATUS_EXHAUSTED;
  assign rep_word     = 32'(cand);

  // Job load, pool run control and result handoff
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= ST_LOAD;
      idx                  <= 6'd0;
      pool_sha_state       <= '0;
      pool_message_head    <= '0;
      pool_difficulty_bm   <= '0;
      pool_nonce_start_MSB <= '0;
      pool_reset_n         <= 1'b0;
`ifdef SHAPOOL_JOB_CTRL_EXHAUST_EN
      wrap_seen            <= 1'b0;
`endif
    end else begin
      case (state)
        ST_LOAD: begin
          if (job_abort) begin
            idx <= 6'd0;
          end else if (rx_fire) begin
            if (idx < OFS_HEAD)      pool_sha_state     <= {pool_sha_state[247:0], host.rx_data};
            else if (idx < OFS_DIFF) pool_message_head  <= {pool_message_head[87:0], host.rx_data};
            else if (idx < OFS_NSM)  pool_difficulty_bm <= {pool_difficulty_bm[7:0], host.rx_data};
            else                     pool_nonce_start_MSB <= host.rx_data;
            if (idx == JOB_LAST) begin
              idx          <= 6'd0;
              state        <= ST_RUN;
              pool_reset_n <= 1'b1;
`ifdef SHAPOOL_JOB_CTRL_EXHAUST_EN
              wrap_seen    <= 1'b0;
`endif
            end else begin
              idx <= idx + 6'd1;
            end
          end
        end
        ST_RUN: begin
          if (job_abort || report_start) begin
            state        <= job_abort ? ST_LOAD : ST_REPORT;
            pool_reset_n <= 1'b0;
          end
`ifdef SHAPOOL_JOB_CTRL_EXHAUST_EN
          else if (&pool_nonce) begin
            wrap_seen <= 1'b1;
          end
`endif
        end
        ST_REPORT: begin
          if (job_abort || tx_done) state <= ST_LOAD;
        end
        default: begin
          state        <= ST_LOAD;
          pool_reset_n <= 1'b0;
        end
      endcase
    end
  end

  shapool_result_tx u_result_tx (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (report_start),
    .flush    (job_abort),
    .status   (rep_status),
    .word     (rep_word),
    .tx_data  (host.tx_data),
    .tx_valid (host.tx_valid),
    .tx_ready (host.tx_ready),
    .done     (tx_done)
  );

endmodule

// File: tb/tb_shapool_job_ctrl.sv
// Scoreboard bench for shapool_job_ctrl: random jobs/nonces against a frame-level reference model.
// Latency: n/a.
// Backpressure: tx_ready randomized except where a directed test forces it.
module tb_shapool_job_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  shapool_job_ctrl_if bus ();

  logic         job_abort;
  logic         pool_reset_n;
  logic [255:0] pool_sha_state;
  logic [95:0]  pool_message_head;
  logic [15:0]  pool_difficulty_bm;
  logic [7:0]   pool_nonce_start_MSB;
  logic         pool_success;
  logic [31:0]  pool_nonce;
  logic         busy;

  shapool_job_ctrl #(.POOL_SIZE_LOG2(0), .NONCE_PIPE_OFFSET(2)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .host                 (bus),
    .job_abort            (job_abort),
    .pool_reset_n         (pool_reset_n),
    .pool_sha_state       (pool_sha_state),
    .pool_message_head    (pool_message_head),
    .pool_difficulty_bm   (pool_difficulty_bm),
    .pool_nonce_start_MSB (pool_nonce_start_MSB),
    .pool_success         (pool_success),
    .pool_nonce           (pool_nonce),
    .busy                 (busy)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] job[47];

  bit rdy_force = 1'b0;
  bit rdy_val   = 1'b1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every accepted result byte is compared with the oldest expected byte
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_unexpected: got byte %0h, required no byte", bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", bus.tx_data, e);
        end
      end
    end
  end

  // Host-side ready: random unless a test pins it
  initial begin
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input bit last);
    repeat ($urandom_range(0, 2)) tick();
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    if (last) check("pool_reset_n_before_last", pool_reset_n, 1'b0);
    tick();
    bus.rx_valid = 1'b0;
    if (last) begin
      check("pool_reset_n_after_last", pool_reset_n, 1'b1);
      check("busy_after_last", busy, 1'b1);
      check("rx_ready_in_run", bus.rx_ready, 1'b0);
    end
  endtask

  task automatic load_job();
    pool_nonce = 32'h0;
    for (int i = 0; i < 47; i++) send_byte(job[i], i == 46);
  endtask

  task automatic random_job();
    for (int i = 0; i < 47; i++) job[i] = 8'($urandom_range(0, 255));
  endtask

  // Reference: fields are the job bytes laid out big-endian
  task automatic check_job();
    logic [255:0] s;
    logic [95:0]  h;
    for (int i = 0; i < 32; i++) s[255 - 8*i -: 8] = job[i];
    for (int i = 0; i < 12; i++) h[95 - 8*i -: 8]  = job[32 + i];
    check("sha_state", pool_sha_state, s);
    check("message_head", pool_message_head, h);
    check("difficulty_bm", pool_difficulty_bm, {job[44], job[45]});
    check("nonce_start_msb", pool_nonce_start_MSB, job[46]);
  endtask

  task automatic push_frame(input logic [7:0] status, input logic [31:0] cand);
    exp_q.push_back(status);
    for (int i = 3; i >= 0; i--) exp_q.push_back(cand[8*i +: 8]);
  endtask

  task automatic run_found(input logic [31:0] nonce, input int pre_cycles);
    for (int i = 0; i < pre_cycles; i++) begin
      pool_nonce = $urandom() & 32'hFFFF_FFFE;
      tick();
    end
    check("busy_in_run", busy, 1'b1);
    push_frame(8'h01, nonce - 32'd2);
    pool_nonce   = nonce;
    pool_success = 1'b1;
    tick();
    pool_success = 1'b0;
    pool_nonce   = $urandom() & 32'hFFFF_FFFE;
    check("pool_reset_n_after_success", pool_reset_n, 1'b0);
    check("tx_valid_after_success", bus.tx_valid, 1'b1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 400) begin
      fails++;
      $display("FAIL %s: timeout with %0d bytes pending busy=%0b, required drained and idle",
               name, exp_q.size(), busy);
    end
    check("rx_ready_after_report", bus.rx_ready, 1'b1);
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    job_abort    = 1'b0;
    pool_success = 1'b0;
    pool_nonce   = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_ready", bus.rx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_pool_reset_n", pool_reset_n, 1'b0);
    check("rst_tx_valid", bus.tx_valid, 1'b0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_sha_state", pool_sha_state, 256'h0);
    reset_n = 1'b1;
    tick();

    // Directed job 0x00..0x2E and found at nonce 0x105 -> 01 00 00 01 03
    for (int i = 0; i < 47; i++) job[i] = 8'(i);
    load_job();
    check_job();
    check("sha_const", pool_sha_state,
          256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F);
    run_found(32'h0000_0105, 3);
    wait_done("found_0105");

    // Random jobs, nonces and ready patterns
    for (int k = 0; k < 6; k++) begin
      random_job();
      load_job();
      check_job();
      run_found($urandom(), $urandom_range(0, 8));
      wait_done("found_random");
    end

    // Back-pressure for 10 cycles, then wrap-around candidate 0xFFFFFFFF
    random_job();
    load_job();
    rdy_force = 1'b1;
    rdy_val   = 1'b0;
    run_found(32'h0000_0001, 2);
    for (int i = 0; i < 10; i++) begin
      check("stall_tx_valid", bus.tx_valid, 1'b1);
      check("stall_tx_data", bus.tx_data, 8'h01);
      tick();
    end
    rdy_force = 1'b0;
    wait_done("found_wrap");

    // Abort and success on the same cycle: abort wins
    random_job();
    load_job();
    pool_nonce   = 32'h0000_1234;
    pool_success = 1'b1;
    job_abort    = 1'b1;
    tick();
    pool_success = 1'b0;
    job_abort    = 1'b0;
    check("abort_tx_valid", bus.tx_valid, 1'b0);
    check("abort_rx_ready", bus.rx_ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_pool_reset_n", pool_reset_n, 1'b0);
    repeat (3) tick();
    check("abort_tx_valid_later", bus.tx_valid, 1'b0);

    // Abort during REPORT drops the frame
    random_job();
    load_job();
    rdy_force = 1'b1;
    rdy_val   = 1'b0;
    run_found(32'h0BAD_F00D, 1);
    job_abort = 1'b1;
    tick();
    job_abort = 1'b0;
    exp_q.delete();
    check("abort_report_tx_valid", bus.tx_valid, 1'b0);
    check("abort_report_busy", busy, 1'b0);
    rdy_force = 1'b0;
    repeat (4) tick();
    check("abort_report_quiet", bus.tx_valid, 1'b0);

    // Abort after 20 bytes of a job; the next 47 bytes form a clean job
    for (int i = 0; i < 20; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    job_abort = 1'b1;
    tick();
    job_abort = 1'b0;
    check("partial_abort_busy", busy, 1'b0);
    random_job();
    load_job();
    check_job();
    run_found($urandom(), 2);
    wait_done("after_partial_abort");

    // Async reset between clock edges in REPORT
    random_job();
    load_job();
    rdy_force = 1'b1;
    rdy_val   = 1'b0;
    run_found(32'h1357_9BDF, 1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_tx_valid", bus.tx_valid, 1'b0);
    check("arst_pool_reset_n", pool_reset_n, 1'b0);
    check("arst_rx_ready", bus.rx_ready, 1'b1);
    check("arst_busy", busy, 1'b0);
    check("arst_sha_state", pool_sha_state, 256'h0);
    check("arst_message_head", pool_message_head, 96'h0);
    check("arst_difficulty_bm", pool_difficulty_bm, 16'h0);
    check("arst_nonce_start_msb", pool_nonce_start_MSB, 8'h0);
    exp_q.delete();
    tick();
    reset_n   = 1'b1;
    rdy_force = 1'b0;
    tick();

`ifdef SHAPOOL_JOB_CTRL_EXHAUST_EN
    // Exhaustion: start 0x80000000, wrap, then return to start + offset -> 02 7F FF FF FF
    random_job();
    job[46] = 8'h80;
    load_job();
    pool_nonce = 32'h8000_0002;
    tick();
    check("no_exhaust_before_wrap", bus.tx_valid, 1'b0);
    check("busy_before_wrap", busy, 1'b1);
    pool_nonce = 32'hFFFF_FFFF;
    tick();
    pool_nonce = 32'h0000_0005;
    tick();
    push_frame(8'h02, 32'h7FFF_FFFF);
    pool_nonce = 32'h8000_0002;
    tick();
    pool_nonce = 32'h0000_0000;
    check("exhaust_pool_reset_n", pool_reset_n, 1'b0);
    check("exhaust_tx_valid", bus.tx_valid, 1'b1);
    wait_done("exhausted");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shapool_job_ctrl.md
Name: shapool_job_ctrl

Overview:
- Host-facing job controller that drives shapool's job-parameter inputs and consumes its result outputs.
- Receives a 47-byte job over a byte stream with a valid/ready handshake and holds the job parameters stable.
- Releases the pool from reset, waits for `success`, corrects the pipelined nonce, and transmits a 5-byte result frame over a second byte stream.
- Sits between the host/SPI byte interface and the shapool instance.

Parameters:
- POOL_SIZE_LOG2, 0: must match the pool instance. Pool nonce width NONCE_WIDTH = 32 - POOL_SIZE_LOG2 (localparam).
- NONCE_PIPE_OFFSET, 2: number of nonce increments between a candidate's launch and its `success` evaluation.

Ports:
- clk  input  1  single system clock, same as the pool.
- reset_n  input  1  asynchronous, active-low reset.
- rx_data  input  8  job byte from the host.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  controller accepts a byte this cycle.
- tx_data  output  8  result byte to the host.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  host accepts a byte.
- job_abort  input  1  one-cycle pulse; cancels RUN or REPORT.
- pool_reset_n  output  1  drives the pool's reset_n (synchronous to the pool).
- pool_sha_state  output  256  job midstate.
- pool_message_head  output  96  job message head.
- pool_difficulty_bm  output  16  difficulty bitmask.
- pool_nonce_start_MSB  output  8  nonce start MSB.
- pool_success  input  1  pool success flag.
- pool_nonce  input  NONCE_WIDTH  pool nonce counter.
- busy  output  1  high in RUN or REPORT.

Behaviour:
- Reset (async): state=LOAD; byte index=0; all job registers 0; pool_reset_n=0; tx_valid=0; tx_data=0; result registers 0.
- rx_ready and busy are decoded from the state register, so rx_ready=1 immediately after reset.
- Handshakes: a byte transfers when valid&&ready on a rising edge. tx_data and tx_valid are registered. Once tx_valid is high, tx_valid and tx_data must not change until tx_ready.
- LOAD:
  - rx_ready=1, pool_reset_n=0.
  - Bytes arrive MSB-first: bytes 0-31 sha_state[255:0], 32-43 message_head, 44-45 difficulty_bm, 46 nonce_start_MSB.
  - Each byte is shifted into its field register when accepted.
  - On acceptance of byte 46: go to RUN and set pool_reset_n=1 on the same edge. Index returns to 0.
  - Idle gaps (rx_valid low) are legal anywhere in the frame.
- RUN:
  - rx_ready=0. Job outputs are constant.
  - On pool_success=1: capture cand = pool_nonce - NONCE_PIPE_OFFSET, computed mod 2^NONCE_WIDTH (wrap-around is legal). Set status=0x01, pool_reset_n=0, go to REPORT.
  - pool_success is ignored in every other state.
- REPORT: send 5 bytes: status, then {POOL_SIZE_LOG2 zeros, cand} as 32 bits MSB-first. After the 5th byte is accepted, go to LOAD. Job registers retain their old values until overwritten.
- job_abort:
  - In RUN or REPORT: go to LOAD next edge; pool_reset_n=0, tx_valid=0, any in-flight frame is dropped.
  - In LOAD: clears the byte index; a partial job is discarded.
  - Priority: job_abort beats pool_success on the same cycle.
- Reset asserted mid-operation returns immediately to the reset values.

Optional Feature:
- Macro: SHAPOOL_JOB_CTRL_EXHAUST_EN.
- With the macro:
  - In RUN, a wrap_seen flag is set when pool_nonce is all-ones.
  - When wrap_seen=1 and pool_nonce == nonce_start + NONCE_PIPE_OFFSET, the nonce space is exhausted: status=0x02, cand=nonce_start-1, go to REPORT.
  - If pool_success occurs on the same cycle, it wins (status 0x01).
  - wrap_seen is cleared on entering RUN.
- Without the macro: RUN waits for success or abort indefinitely; no wrap logic is synthesised.

Decomposition:
- Shared package shapool_pkg:
  - Job frame length (47) and field byte offsets.
  - Result frame length (5).
  - Status codes STATUS_FOUND=0x01, STATUS_EXHAUSTED=0x02.
  - State encoding LOAD/RUN/REPORT.
  - Default NONCE_PIPE_OFFSET.
- One sub-module, shapool_result_tx: 5-byte registered serializer with valid/ready handshake and a flush input (used for abort).

Test Plan:
- Job load: stream bytes 0x00..0x2E with random rx_valid gaps → pool_sha_state=0x000102..1F, pool_message_head=0x202122..2B, pool_difficulty_bm=0x2C2D, pool_nonce_start_MSB=0x2E; pool_reset_n rises the same edge byte 46 is accepted; busy=1.
- Found: in RUN, pool_nonce=0x00000105 with pool_success pulse → tx frame 01 00 00 01 03 (POOL_SIZE_LOG2=0); pool_reset_n=0 the next cycle.
- Back-pressure and wrap: hold tx_ready=0 for 10 cycles → tx_valid stays 1 and tx_data stays stable. Then success with pool_nonce=0x00000001 → cand=0xFFFFFFFF, frame 01 FF FF FF FF.
- Abort: pool_success and job_abort in the same cycle → no tx_valid; state=LOAD; rx_ready=1. Abort after 20 job bytes → the next 47 bytes form a clean job.
- Async reset: drop reset_n mid-REPORT, between clock edges → tx_valid=0, pool_reset_n=0, rx_ready=1, all job outputs 0 without waiting for a clock edge.
- EXHAUST_EN, POOL_SIZE_LOG2=0, nonce_start_MSB=0x80: drive pool_nonce 0xFFFFFFFF, then 0x80000002 → frame 02 80 00 00 00 minus 1, i.e. 02 7F FF FF FF.
